// File: rtl/rv32_issue_scoreboard_pkg.sv
// Shared RV32 pipeline types: register ids, scoreboard FSM states and the
// decode-side request seen by the issue scoreboard.
package rv32_types;

  typedef logic [4:0] rv_reg_id_t;

  typedef enum logic [1:0] {
    SB_RUN    = 2'd0,
    SB_HAZARD = 2'd1,
    SB_DRAIN  = 2'd2,
    SB_FLUSH  = 2'd3
  } sb_state_t;

  typedef struct packed {
    rv_reg_id_t rs1;
    rv_reg_id_t rs2;
    rv_reg_id_t rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_fence;
  } sb_decode_req_t;

endpackage

// File: rtl/rv32_issue_scoreboard_if.sv
// Decode/execute/writeback handshake bundle for the issue scoreboard.
// The pipeline side drives through master; the scoreboard uses slave.
interface rv32_issue_scoreboard_if #(
  parameter int PERF_W = 32
);
  import rv32_types::*;

  logic              dec_valid;
  sb_decode_req_t    dec_req;
  logic              ex_ready;
  logic              wb_valid;
  rv_reg_id_t        wb_rd;
  logic              redirect;
  logic              issue;
  logic              stall_fetch;
  logic              stall_decode;
  logic              flush_fetch;
  logic              flush_decode;
  logic              sb_empty;
  logic [PERF_W-1:0] stall_cycles;
  logic              sb_err;

  modport master (
    output dec_valid, dec_req, ex_ready, wb_valid, wb_rd, redirect,
    input  issue, stall_fetch, stall_decode, flush_fetch, flush_decode,
           sb_empty, stall_cycles, sb_err
  );

  modport slave (
    input  dec_valid, dec_req, ex_ready, wb_valid, wb_rd, redirect,
    output issue, stall_fetch, stall_decode, flush_fetch, flush_decode,
           sb_empty, stall_cycles, sb_err
  );

endinterface

// File: rtl/rv32_issue_scoreboard_pending_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
// Simultaneous inc and dec leave the count unchanged.
module rv32_pending_counter #(
  parameter int MAX_INFLIGHT = 3,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_full,
  output logic o_zero_nxt,
  output logic o_full_nxt,
  output logic o_err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    case ({i_inc, i_dec})
      2'b10: begin
        if (r_count != MAX_C) w_count_nxt = r_count + CW'(1'b1);
        else                  w_count_nxt = r_count;
      end
      2'b01: begin
        if (r_count != '0) w_count_nxt = r_count - CW'(1'b1);
        else               w_count_nxt = r_count;
      end
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_count <= '0;
    else         r_count <= w_count_nxt;
  end

  assign o_zero     = (r_count == '0);
  assign o_full     = (r_count == MAX_C);
  assign o_zero_nxt = (w_count_nxt == '0);
  assign o_full_nxt = (w_count_nxt == MAX_C);
  // A retirement against an idle counter means the pipeline lost track of a write.
  assign o_err      = i_dec && (r_count == '0);

endmodule

// File: rtl/rv32_issue_scoreboard.sv
// Decode-to-execute issue controller: per-register pending-write tracking,
// issue decision, fetch/decode stall and flush control, fence drain sequencing.
module rv32_issue_scoreboard
  import rv32_types::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int PERF_W       = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  rv32_issue_scoreboard_if.slave  sb
);

  sb_state_t         r_state;
  sb_state_t         w_state_nxt;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              r_sb_err;

  logic [31:0] w_zero_v;
  logic [31:0] w_full_v;
  logic [31:0] w_zero_nxt_v;
  logic [31:0] w_full_nxt_v;
  logic [31:1] w_inc_v;
  logic [31:1] w_dec_v;
  logic [31:1] w_err_v;

  logic w_raw, w_full, w_fence_block, w_empty;
  logic w_raw_nxt, w_full_nxt, w_fence_nxt, w_empty_nxt;
  logic w_issue, w_stall, w_flush;

  // x0 is hard-wired idle so it can never raise a hazard.
  assign w_zero_v[0]     = 1'b1;
  assign w_full_v[0]     = 1'b0;
  assign w_zero_nxt_v[0] = 1'b1;
  assign w_full_nxt_v[0] = 1'b0;

  generate
    for (genvar g = 1; g < 32; g++) begin : g_pend
      assign w_inc_v[g] = w_issue && sb.dec_req.writes_rd && (sb.dec_req.rd == 5'(g));
      assign w_dec_v[g] = sb.wb_valid && (sb.wb_rd == 5'(g));

      rv32_pending_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
      ) u_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .i_inc      (w_inc_v[g]),
        .i_dec      (w_dec_v[g]),
        .o_zero     (w_zero_v[g]),
        .o_full     (w_full_v[g]),
        .o_zero_nxt (w_zero_nxt_v[g]),
        .o_full_nxt (w_full_nxt_v[g]),
        .o_err      (w_err_v[g])
      );
    end
  endgenerate

  assign w_empty       = &w_zero_v;
  assign w_raw         = (sb.dec_req.uses_rs1 && !w_zero_v[sb.dec_req.rs1]) ||
                         (sb.dec_req.uses_rs2 && !w_zero_v[sb.dec_req.rs2]);
  assign w_full        = sb.dec_req.writes_rd && w_full_v[sb.dec_req.rd];
  assign w_fence_block = sb.dec_req.is_fence && !w_empty;

  // HAZARD looks at the counts after this cycle's writeback so the held
  // instruction can issue on the very next cycle.
  assign w_empty_nxt   = &w_zero_nxt_v;
  assign w_raw_nxt     = (sb.dec_req.uses_rs1 && !w_zero_nxt_v[sb.dec_req.rs1]) ||
                         (sb.dec_req.uses_rs2 && !w_zero_nxt_v[sb.dec_req.rs2]);
  assign w_full_nxt    = sb.dec_req.writes_rd && w_full_nxt_v[sb.dec_req.rd];
  assign w_fence_nxt   = sb.dec_req.is_fence && !w_empty_nxt;

  // Next-state and issue/stall/flush decode; redirect wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    if (resetn) begin
      w_issue = sb.dec_valid && (r_state == SB_RUN) && sb.ex_ready && !sb.redirect &&
                !w_raw && !w_full && !w_fence_block;
      w_stall = sb.dec_valid && !w_issue && !sb.redirect && (r_state != SB_FLUSH);
      w_flush = sb.redirect || (r_state == SB_FLUSH);
    end else begin
      w_issue = 1'b0;
      w_stall = 1'b0;
      w_flush = 1'b0;
    end
    case (r_state)
      SB_RUN: begin
        if (sb.redirect)                                w_state_nxt = SB_FLUSH;
        else if (sb.dec_valid && (w_raw || w_full))     w_state_nxt = SB_HAZARD;
        else if (sb.dec_valid && w_fence_block)         w_state_nxt = SB_DRAIN;
        else                                            w_state_nxt = SB_RUN;
      end
      SB_HAZARD: begin
        if (sb.redirect)                                w_state_nxt = SB_FLUSH;
        else if (!sb.dec_valid)                         w_state_nxt = SB_RUN;
        else if (w_raw_nxt || w_full_nxt)               w_state_nxt = SB_HAZARD;
        else if (w_fence_nxt)                           w_state_nxt = SB_DRAIN;
        else                                            w_state_nxt = SB_RUN;
      end
      SB_DRAIN: begin
        if (sb.redirect)                                w_state_nxt = SB_FLUSH;
        else if (w_empty)                               w_state_nxt = SB_RUN;
        else                                            w_state_nxt = SB_DRAIN;
      end
      SB_FLUSH:                                         w_state_nxt = SB_RUN;
      default:                                          w_state_nxt = SB_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= SB_RUN;
    else         r_state <= w_state_nxt;
  end

  // Saturating count of decode-valid cycles that did not issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                              r_stall_cycles <= '0;
    else if (sb.dec_valid && !w_issue && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + PERF_W'(1'b1);
    else                                                      r_stall_cycles <= r_stall_cycles;
  end

  // Sticky writeback-underflow flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_sb_err <= 1'b0;
    else if (|w_err_v) r_sb_err <= 1'b1;
    else              r_sb_err <= r_sb_err;
  end

  assign sb.issue        = w_issue;
  assign sb.stall_fetch  = w_stall;
  assign sb.stall_decode = w_stall;
  assign sb.flush_fetch  = w_flush;
  assign sb.flush_decode = w_flush;
  assign sb.sb_empty     = w_empty;
  assign sb.stall_cycles = r_stall_cycles;
  assign sb.sb_err       = r_sb_err;

endmodule

// File: doc/rv32_issue_scoreboard.md
# rv32_issue_scoreboard

Issue controller that sits between the decode and execute stages. It tracks pending register writes with per-register in-flight counters and decides each cycle whether the decoded instruction may issue. It also generates the stall and flush controls for the fetch and decode buffers, and sequences fence drains and branch-redirect flushes. All instructions that have passed decode always complete; only fetch and decode contents are ever squashed.

## Interface
Parameters:
- MAX_INFLIGHT, 3: maximum outstanding writes per register; counter width is $clog2(MAX_INFLIGHT+1).
- PERF_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  reset, asynchronous, active-low.
- dec_valid  in  1  decode buffer holds a valid instruction.
- dec_req  in  sb_decode_req_t  rs1, rs2, rd (rv_reg_id_t), uses_rs1, uses_rs2, writes_rd, is_fence.
- ex_ready  in  1  execute stage accepts an instruction this cycle.
- wb_valid  in  1  a register write retires this cycle.
- wb_rd  in  5  destination of the retiring write.
- redirect  in  1  taken branch or jump resolved in execute.
- issue  out  1  decoded instruction transfers to execute this cycle.
- stall_fetch  out  1  fetch buffer holds.
- stall_decode  out  1  decode buffer holds.
- flush_fetch  out  1  fetch buffer loads a NOP.
- flush_decode  out  1  decode buffer loads a NOP.
- sb_empty  out  1  all pending counters are zero.
- stall_cycles  out  PERF_W  saturating count of cycles with dec_valid and no issue.
- sb_err  out  1  sticky: writeback to a register whose counter was zero.

## Operation
- Per register r (1..31), a counter pend[r] is kept. x0 is never pending; issues and writebacks to x0 are ignored.
- Hazards:
  - raw = (uses_rs1 && pend[rs1]!=0) || (uses_rs2 && pend[rs2]!=0).
  - full = writes_rd && pend[rd]==MAX_INFLIGHT.
  - fence_block = is_fence && !sb_empty.
- Issue: issue = dec_valid && state==RUN && ex_ready && !redirect && !raw && !full && !fence_block.
- Stalls: stall_fetch = stall_decode = dec_valid && !issue && !redirect && state!=FLUSH.
- States (sb_state_t):
  - RUN: normal operation.
    - redirect → FLUSH.
    - raw or full → HAZARD.
    - fence_block → DRAIN.
  - HAZARD: re-evaluates the same conditions each cycle.
    - Returns to RUN in the same cycle that issue would be legal; that instruction issues from RUN on the next cycle.
    - redirect → FLUSH.
  - DRAIN: waits for sb_empty, then → RUN. redirect → FLUSH.
  - FLUSH: lasts one cycle. dec_valid is ignored, issue=0, stalls=0. Always → RUN.
- Flush outputs:
  - flush_fetch = flush_decode = redirect || state==FLUSH.
  - redirect has priority over every other condition.
- Counter update at each edge:
  - pend[rd] += issue && writes_rd.
  - pend[wb_rd] −= wb_valid.
  - If both hit the same register in the same cycle, the counter is unchanged.
- Writeback with pend==0: counter stays 0 and sb_err sets. sb_err clears only on reset.
- No same-cycle writeback bypass: a hazard cleared by writeback releases issue on the following cycle.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - All pend = 0, state = RUN, stall_cycles = 0, sb_err = 0.
  - While resetn is low: issue = 0, stalls = 0, flushes = 0, sb_empty = 1.
- issue, stall_* and flush_* are combinational from state, pend and inputs.
- pend, state, stall_cycles and sb_err are registered.
- Minimum RAW penalty: dependent instruction issues ≥1 cycle after the producer's wb_valid cycle.
- stall_cycles saturates at all-ones.
- Reset mid-stall or mid-flush discards all in-flight tracking. The environment resets the whole pipeline together.

## Structure
- Add to the shared rv32_types package:
  - sb_state_t (RUN, HAZARD, DRAIN, FLUSH).
  - sb_decode_req_t.
- rv_reg_id_t is reused.
- One sub-module: rv32_pending_counter, a single saturating up/down counter with inc, dec, zero, full and err outputs. It is instantiated 31 times via generate.

## Test plan
- Reset, then dec_valid with uses_rs1, rs1=5, pend all zero, ex_ready=1 → issue=1 on the first cycle, stall_cycles=0.
- Issue a write to x5. Next cycle, decode reads x5 → stall_fetch=stall_decode=1 and state=HAZARD. On wb_valid with wb_rd=5, issue=0 that cycle and issue=1 one cycle later; stall_cycles counts the stalled cycles.
- Issue three writes to x7 without writeback (MAX_INFLIGHT=3), then a fourth → stalled by full. One wb_rd=7 → the fourth issues the next cycle with pend[7]=3.
- Same-cycle issue to x9 and wb_rd=9 with pend[9]=1 → pend[9] stays 1. Writeback to x10 with pend[10]=0 → sb_err=1 and stays 1 until reset.
- is_fence with pend[3]=2 → DRAIN. After two writebacks, sb_empty=1 and the fence issues.
- redirect while in HAZARD → flush_fetch=flush_decode=1 for 2 cycles, issue=0, then RUN. Writes to x0 never stall.
